// File: rtl/wall_ctrl_multi.sv
// Multi-wall controller: one shared DEL/UPDATE/DRAW sequencer services NUM_WALLS walls in index order per tick.
// Optional WALL_AUTORESPAWN_EN: stopped walls return to READY after RESPAWN_PASSES untouched passes.
module wall_ctrl_multi #(
   parameter int NUM_WALLS      = 4,
   parameter int IDX_W          = 2,
   parameter int RESPAWN_PASSES = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   tick,
   input  logic [NUM_WALLS-1:0]   go,
   input  logic [NUM_WALLS-1:0]   touched,
   output logic [IDX_W-1:0]       wall_sel,
   output logic                   del_en,
   output logic                   update_en,
   output logic                   draw_en,
   output logic [4*NUM_WALLS-1:0] wall_state,
   output logic                   pass_busy,
   output logic                   pass_done,
   output logic                   tick_miss
);

   localparam logic [3:0] ST_READY  = 4'b0101;
   localparam logic [3:0] ST_MOVE   = 4'b0110;
   localparam logic [3:0] ST_STOP   = 4'b0111;
   localparam logic [3:0] ST_DRAW   = 4'b1000;
   localparam logic [3:0] ST_DEL    = 4'b1001;
   localparam logic [3:0] ST_UPDATE = 4'b1010;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

   typedef enum logic [2:0] {SEQ_IDLE, SEQ_SCAN, SEQ_DEL, SEQ_UPDATE, SEQ_DRAW} seq_t;

   seq_t             seq;
   logic [3:0]       lane [NUM_WALLS];
   logic [3:0]       after_st;
   logic [3:0]       cur;
   logic [IDX_W-1:0] nxt;
   logic             last;
   logic             adv;
`ifdef WALL_AUTORESPAWN_EN
   logic [7:0]       stop_cnt [NUM_WALLS];
`endif

   function automatic logic serviced(input logic [3:0] c);
      return (c == ST_READY) || (c == ST_MOVE);
   endfunction

   assign cur  = lane[wall_sel];
   assign nxt  = wall_sel + IDX_W'(1);
   assign last = (wall_sel == LAST_IDX);
   // A pass moves to the next wall after DRAW, or straight out of SCAN when the wall is not drawn.
   assign adv  = (seq == SEQ_DRAW) || ((seq == SEQ_SCAN) && !serviced(cur));

   for (genvar i = 0; i < NUM_WALLS; i++) begin : g_pack
      assign wall_state[4*i +: 4] = lane[i];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seq       <= SEQ_IDLE;
         wall_sel  <= '0;
         del_en    <= 1'b0;
         update_en <= 1'b0;
         draw_en   <= 1'b0;
         pass_busy <= 1'b0;
         pass_done <= 1'b0;
         tick_miss <= 1'b0;
         after_st  <= ST_READY;
         for (int i = 0; i < NUM_WALLS; i++) begin
            lane[i] <= ST_READY;
`ifdef WALL_AUTORESPAWN_EN
            stop_cnt[i] <= 8'd0;
`endif
         end
      end else begin
         del_en    <= 1'b0;
         update_en <= 1'b0;
         draw_en   <= 1'b0;
         pass_done <= 1'b0;
         tick_miss <= tick && (seq != SEQ_IDLE);
         case (seq)
            SEQ_IDLE: begin
               if (tick) begin
                  seq       <= SEQ_SCAN;
                  wall_sel  <= '0;
                  pass_busy <= 1'b1;
                  pass_done <= (NUM_WALLS == 1) && !serviced(lane[0]);
               end
            end
            SEQ_SCAN: begin
               case (cur)
                  ST_READY: begin
                     after_st       <= go[wall_sel] ? ST_MOVE : ST_READY;
                     lane[wall_sel] <= ST_DEL;
                     del_en         <= 1'b1;
                     seq            <= SEQ_DEL;
                  end
                  ST_MOVE: begin
                     after_st       <= touched[wall_sel] ? ST_STOP : ST_MOVE;
                     lane[wall_sel] <= ST_DEL;
                     del_en         <= 1'b1;
                     seq            <= SEQ_DEL;
                  end
                  ST_STOP: begin
                     if (touched[wall_sel]) begin
                        lane[wall_sel] <= ST_READY;
`ifdef WALL_AUTORESPAWN_EN
                        stop_cnt[wall_sel] <= 8'd0;
                     end else if (stop_cnt[wall_sel] + 8'd1 == 8'(RESPAWN_PASSES)) begin
                        lane[wall_sel]     <= ST_READY;
                        stop_cnt[wall_sel] <= 8'd0;
                     end else begin
                        stop_cnt[wall_sel] <= stop_cnt[wall_sel] + 8'd1;
`endif
                     end
                  end
                  default: lane[wall_sel] <= ST_READY;
               endcase
            end
            SEQ_DEL: begin
               lane[wall_sel] <= ST_UPDATE;
               update_en      <= 1'b1;
               seq            <= SEQ_UPDATE;
            end
            SEQ_UPDATE: begin
               lane[wall_sel] <= ST_DRAW;
               draw_en        <= 1'b1;
               pass_done      <= last;
               seq            <= SEQ_DRAW;
            end
            SEQ_DRAW: begin
               lane[wall_sel] <= after_st;
`ifdef WALL_AUTORESPAWN_EN
               if (after_st == ST_STOP) stop_cnt[wall_sel] <= 8'd0;
`endif
            end
            default: seq <= SEQ_IDLE;
         endcase
         // pass_done is predicted one cycle early so it lands on the final SCAN or DRAW cycle.
         if (adv) begin
            if (last) begin
               seq       <= SEQ_IDLE;
               wall_sel  <= '0;
               pass_busy <= 1'b0;
            end else begin
               seq       <= SEQ_SCAN;
               wall_sel  <= nxt;
               pass_done <= (nxt == LAST_IDX) && !serviced(lane[nxt]);
            end
         end
      end
   end

endmodule

// File: tb/tb_wall_ctrl_multi.sv
// Directed bench for wall_ctrl_multi (4 walls); each pass is checked cycle by cycle against an expected phase queue.
module tb_wall_ctrl_multi;

   localparam int W = 4;

   logic        clk;
   logic        resetn;
   logic        tick;
   logic [3:0]  go;
   logic [3:0]  touched;
   logic [1:0]  wall_sel;
   logic        del_en;
   logic        update_en;
   logic        draw_en;
   logic [15:0] wall_state;
   logic        pass_busy;
   logic        pass_done;
   logic        tick_miss;

   logic [W-1:0] exp_q[$];
   int n_checks;
   int n_errors;

   wall_ctrl_multi #(.NUM_WALLS(4), .IDX_W(2), .RESPAWN_PASSES(3)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tick       (tick),
      .go         (go),
      .touched    (touched),
      .wall_sel   (wall_sel),
      .del_en     (del_en),
      .update_en  (update_en),
      .draw_en    (draw_en),
      .wall_state (wall_state),
      .pass_busy  (pass_busy),
      .pass_done  (pass_done),
      .tick_miss  (tick_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Ticks one pass; svc marks walls expected to get DEL/UPDATE/DRAW. miss_at >= 0 re-pulses tick at that cycle.
   task automatic run_pass(input logic [3:0] svc, input int miss_at);
      logic [W-1:0] e;
      logic [1:0]   k;
      logic [1:0]   ph;
      logic [7:0]   obs;
      logic [7:0]   exv;
      logic [3:0]   code;
      int           len;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({2'(i), 2'd0});
         if (svc[i]) for (int p = 1; p < 4; p++) exp_q.push_back({2'(i), 2'(p)});
      end
      len = exp_q.size();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int n = 0; n < len; n++) begin
         e   = exp_q.pop_front();
         k   = e[3:2];
         ph  = e[1:0];
         obs = {wall_sel, del_en, update_en, draw_en, pass_done, pass_busy, tick_miss};
         exv = {k, ph == 2'd1, ph == 2'd2, ph == 2'd3, n == len - 1, 1'b1,
                (miss_at >= 0) && (n == miss_at + 1)};
         check($sformatf("cyc%0d", n), 32'(obs), 32'(exv));
         if (ph != 2'd0) begin
            code = (ph == 2'd1) ? 4'b1001 : (ph == 2'd2) ? 4'b1010 : 4'b1000;
            check($sformatf("lane%0d_ph%0d", k, ph), 32'(wall_state[4*k +: 4]), 32'(code));
         end
         tick = (n == miss_at);
         @(negedge clk);
      end
      tick = 1'b0;
      check("idle_after", 32'({pass_busy, del_en, update_en, draw_en, pass_done}), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetn   = 1'b0;
      tick     = 1'b0;
      go       = 4'b0000;
      touched  = 4'b0000;
      repeat (2) @(negedge clk);
      check("rst_lanes", 32'(wall_state), 32'h5555);
      check("rst_outs", 32'({wall_sel, del_en, update_en, draw_en, pass_busy, pass_done, tick_miss}), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_pass(4'b1111, -1);
      check("all_ready", 32'(wall_state), 32'h5555);

      go = 4'b0101;
      run_pass(4'b1111, -1);
      go = 4'b0000;
      check("go_0101", 32'(wall_state), 32'h5656);

      go = 4'b1111;
      run_pass(4'b1111, -1);
      go = 4'b0000;
      check("all_move", 32'(wall_state), 32'h6666);

      touched = 4'b0010;
      run_pass(4'b1111, -1);
      touched = 4'b0000;
      check("w1_stop", 32'(wall_state), 32'h6676);

      run_pass(4'b1101, -1);
      check("w1_still_stop", 32'(wall_state), 32'h6676);

      touched = 4'b0010;
      run_pass(4'b1101, -1);
      touched = 4'b0000;
      check("w1_ready", 32'(wall_state), 32'h6656);

      run_pass(4'b1111, 4);
      check("miss_pass_lanes", 32'(wall_state), 32'h6656);

      // Async reset in the middle of wall 2 UPDATE (pass cycle 11).
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_upd", 32'({wall_sel, update_en}), 32'({2'd2, 1'b1}));
      #2 resetn = 1'b0;
      #1;
      check("async_outs", 32'({del_en, update_en, draw_en, pass_busy, pass_done}), 32'd0);
      check("async_lanes", 32'(wall_state), 32'h5555);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_pass(4'b1111, -1);
      check("fresh_pass", 32'(wall_state), 32'h5555);

      go = 4'b0001;
      run_pass(4'b1111, -1);
      go = 4'b0000;
      touched = 4'b0001;
      run_pass(4'b1111, -1);
      touched = 4'b0000;
      check("w0_stop", 32'(wall_state), 32'h5557);
`ifdef WALL_AUTORESPAWN_EN
      run_pass(4'b1110, -1);
      run_pass(4'b1110, -1);
      check("respawn_p2", 32'(wall_state), 32'h5557);
      run_pass(4'b1110, -1);
      check("respawn_p3", 32'(wall_state), 32'h5555);
`else
      for (int p = 0; p < 10; p++) run_pass(4'b1110, -1);
      check("no_respawn", 32'(wall_state), 32'h5557);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wall_ctrl_multi.md
Name: wall_ctrl_multi

Overview:
- Parametrised successor of the single-wall controller. Controls NUM_WALLS independent walls, each with its own READY/MOVE/STOP state.
- A single shared DEL→UPDATE→DRAW sequencer services the walls one at a time in fixed index order, once per frame tick.
- Sits between game logic (go/touched per wall) and the shared VGA erase/update/draw datapath, which it drives through wall_sel and the phase strobes.

Parameters:
- NUM_WALLS, 4: number of walls; 1..16.
- IDX_W, 2: width of wall_sel; must be at least clog2(NUM_WALLS), minimum 1.
- RESPAWN_PASSES, 8: passes a wall stays STOP before auto-return. Used only with WALL_AUTORESPAWN_EN; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- tick  in  1  frame tick; starts one service pass when idle
- go  in  NUM_WALLS  per-wall start request
- touched  in  NUM_WALLS  per-wall collision flag
- wall_sel  out  IDX_W  index of wall currently scanned or serviced
- del_en  out  1  erase phase strobe for wall_sel
- update_en  out  1  position-update phase strobe for wall_sel
- draw_en  out  1  draw phase strobe for wall_sel
- wall_state  out  4*NUM_WALLS  packed per-wall 4-bit code; wall i occupies bits [4i+3:4i]
- pass_busy  out  1  high while a pass is in progress
- pass_done  out  1  one-cycle pulse on the last cycle of a pass
- tick_miss  out  1  one-cycle pulse when tick arrives while busy

Behaviour:
- State codes are shared with the existing wall logic: READY=4'b0101, MOVE=4'b0110, STOP=4'b0111, DRAW=4'b1000, DEL=4'b1001, UPDATE=4'b1010.
- Reset (resetn low, asynchronous; immediate even mid-pass):
  - every wall_state lane = READY; sequencer = IDLE; wall_sel = 0;
  - all strobes, pass_busy, pass_done and tick_miss = 0; any pass in progress is abandoned.
- Sequencer states: IDLE, SCAN, DEL, UPDATE, DRAW.
- IDLE: tick=1 → SCAN with wall_sel=0; pass_busy rises on the next cycle.
- SCAN (1 cycle, wall k = wall_sel):
  - Wall k READY: latch after_k = go[k] ? MOVE : READY, then go to DEL.
  - Wall k MOVE: latch after_k = touched[k] ? STOP : MOVE, then go to DEL.
  - Wall k STOP: not drawn. If touched[k]=1 it becomes READY in this cycle, otherwise it stays STOP. Advance to the next wall.
  - Any illegal lane code is forced to READY and the wall is skipped.
- DEL, UPDATE, DRAW: one cycle each.
  - The matching strobe is high for exactly that cycle; the three strobes are one-hot or all zero.
  - Wall k's lane shows DEL, UPDATE, then DRAW during the corresponding cycle.
  - On exit from DRAW, lane k takes after_k.
- Advance:
  - If k < NUM_WALLS-1: wall_sel ← k+1, go to SCAN.
  - Otherwise: pass_done=1 in that cycle (the final SCAN or DRAW), then IDLE with wall_sel ← 0.
- Timing: go/touched are sampled only in the SCAN cycle of their own wall; changes on a wall's inputs outside that cycle have no effect on it.
- Pass length: NUM_WALLS + 3×(walls serviced) cycles.
- tick while pass_busy=1: ignored for sequencing; tick_miss pulses for 1 cycle.
- tick coincident with pass_done: also a miss. The next pass needs a tick while in IDLE.
- Lanes of walls not currently selected hold their value.
- NUM_WALLS=1: wall_sel is constant 0.

Optional Feature:
- Macro: WALL_AUTORESPAWN_EN
- Defined:
  - each wall has an 8-bit stop counter, cleared on entry to STOP;
  - the counter increments at each SCAN of that wall while it is STOP and touched=0;
  - when it reaches RESPAWN_PASSES the wall becomes READY at that SCAN and the counter clears;
  - touched=1 still returns the wall to READY immediately;
  - counters reset to 0.
- Undefined: no counters are present; STOP leaves only via touched, or via reset.

Test Plan:
- Reset, NUM_WALLS=4, go=0, one tick → 4 SCAN cycles each followed by DEL/UPDATE/DRAW; pass_done on cycle 16 after busy rises; all lanes READY; strobe sequence correct with wall_sel 0,1,2,3.
- go=4'b0101, tick → walls 0 and 2 MOVE after their DRAW, walls 1 and 3 READY; during wall 2 DEL cycle lane 2 reads 4'b1001.
- Walls 0–3 MOVE, touched=4'b0010, tick → wall 1 STOP. Next tick with touched=0: 13-cycle pass, wall 1 skipped with no strobes at wall_sel=1. Next tick with touched[1]=1 → wall 1 READY.
- Tick pulsed again 5 cycles after the start of a pass → tick_miss=1 for one cycle; pass length and outputs unchanged.
- resetn low during wall 2 UPDATE → strobes 0 immediately (asynchronous), all lanes READY, pass_busy 0; next tick starts a fresh pass at wall 0.
- WALL_AUTORESPAWN_EN defined, RESPAWN_PASSES=3, wall 0 STOP, touched=0 → wall 0 READY at the SCAN of the 3rd subsequent pass; macro undefined → still STOP after 10 passes.
